// File: rtl/memory_game_controller.sv
`timescale 1ns/1ps
// Game sequencer for the 5x4 memory board: debounces the three buttons, moves the cursor,
// sequences first/second picks, compares pairs and holds mismatches visible for a while.
module memory_game_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SHOW_CYCLES     = 25000000
) (
    input  logic         clock_25M,
    input  logic         reset,
    input  logic         new_game,
    input  logic         select,
    input  logic         move_x,
    input  logic         move_y,
    input  logic [99:0]  card_order,
    output logic [4:0]   cursor_pos,
    output logic [19:0]  revealed,
    output logic [19:0]  matched,
    output logic         game_won,
    output logic [7:0]   attempts
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (SHOW_CYCLES > 0) ? $clog2(SHOW_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES);

    typedef enum logic [2:0] {PICK1, PICK2, COMPARE, SHOW, WON} state_t;

    logic          restart;
    logic [2:0]    buttons;
    logic [2:0]    sync1_q, sync2_q, stable_q, press_q;
    logic [CW-1:0] debCnt_q [3];
    logic          selPress, xPress, yPress;

    assign restart = reset | new_game;
    assign buttons = {select, move_x, move_y};
    assign {selPress, xPress, yPress} = press_q;

    // A level is accepted after DEBOUNCE_CYCLES consecutive synced samples that differ
    // from the accepted level; only an accepted fall (press) produces a pulse.
    always_ff @(posedge clock_25M) begin
        if (restart) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            press_q  <= '0;
            for (int b = 0; b < 3; b++) debCnt_q[b] <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            for (int b = 0; b < 3; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] == stable_q[b]) begin
                    debCnt_q[b] <= '0;
                end else if (debCnt_q[b] == CNT_MAX) begin
                    stable_q[b] <= sync2_q[b];
                    debCnt_q[b] <= '0;
                    press_q[b]  <= ~sync2_q[b];
                end else begin
                    debCnt_q[b] <= debCnt_q[b] + 1'b1;
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [4:0]    cursor_q, cursor_d, first_q, first_d, second_q, second_d;
    logic [19:0]   revealed_q, revealed_d, matched_q, matched_d;
    logic [7:0]    attempts_q, attempts_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    cursorAfterY, cursorAfterX;
    logic [19:0]   pairMask;
    logic          pairMatch;

    // Row step wraps inside the column; column step wraps 0 -> 4 through the board.
    assign cursorAfterY = yPress ? ((cursor_q[1:0] == 2'd3) ? cursor_q - 5'd3 : cursor_q + 5'd1) : cursor_q;
    assign cursorAfterX = xPress ? ((cursorAfterY < 5'd4) ? cursorAfterY + 5'd16 : cursorAfterY - 5'd4) : cursorAfterY;
    assign pairMask     = (20'd1 << first_q) | (20'd1 << second_q);
    assign pairMatch    = card_order[first_q*5+1 +: 4] == card_order[second_q*5+1 +: 4];

    always_ff @(posedge clock_25M) begin
        if (restart) begin
            state_q    <= PICK1;
            cursor_q   <= '0;
            first_q    <= '0;
            second_q   <= '0;
            revealed_q <= '0;
            matched_q  <= '0;
            attempts_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            first_q    <= first_d;
            second_q   <= second_d;
            revealed_q <= revealed_d;
            matched_q  <= matched_d;
            attempts_q <= attempts_d;
            timer_q    <= timer_d;
        end
    end

    // Selects act on the pre-move cursor; the cursor itself freezes only once the game is won.
    always_comb begin
        state_d    = state_q;
        cursor_d   = (state_q != WON) ? cursorAfterX : cursor_q;
        first_d    = first_q;
        second_d   = second_q;
        revealed_d = revealed_q;
        matched_d  = matched_q;
        attempts_d = attempts_q;
        timer_d    = timer_q;
        case (state_q)
            PICK1: begin
                if (selPress && !matched_q[cursor_q]) begin
                    revealed_d[cursor_q] = 1'b1;
                    first_d              = cursor_q;
                    state_d              = PICK2;
                end
            end
            PICK2: begin
                if (selPress && !revealed_q[cursor_q] && !matched_q[cursor_q]) begin
                    revealed_d[cursor_q] = 1'b1;
                    second_d             = cursor_q;
                    state_d              = COMPARE;
                end
            end
            COMPARE: begin
                attempts_d = (attempts_q != 8'hFF) ? attempts_q + 8'd1 : attempts_q;
                if (pairMatch) begin
                    matched_d  = matched_q | pairMask;
                    revealed_d = revealed_q & ~pairMask;
                    state_d    = (&(matched_q | pairMask)) ? WON : PICK1;
                end else begin
                    timer_d = SHOW_LOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (timer_q <= TW'(1)) begin
                    revealed_d = revealed_q & ~pairMask;
                    timer_d    = '0;
                    state_d    = PICK1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WON: begin
                state_d = WON;
            end
            default: state_d = PICK1;
        endcase
    end

    assign cursor_pos = cursor_q;
    assign revealed   = revealed_q;
    assign matched    = matched_q;
    assign attempts   = attempts_q;
    assign game_won   = (state_q == WON);

endmodule
